// File: rtl/fdiv_arbiter.sv
// -----------------------------------------------------------------------------
// fdiv_arbiter
//   Shares one fixed-latency pipelined floating-point divider between NUM_REQ
//   requesters. A round-robin arbiter grants at most one request per cycle.
//   The granted operands are registered onto div_a/div_b. A tag pipeline
//   records which requester owns each operation. When the quotient emerges,
//   it is returned to that requester with a one-cycle strobe.
//
// Ports
//   clk, reset_n  : rising-edge clock, asynchronous active-low reset
//   req_valid     : per-requester request (NUM_REQ bits)
//   req_a, req_b  : packed 32-bit operands; requester i uses bits [32i+31:32i]
//   req_ready     : one-hot combinational grant
//   div_a, div_b  : registered operands driven to the divider
//   div_result    : divider quotient, valid DIV_LATENCY cycles after div_a/div_b
//   rsp_valid     : one-hot single-cycle result strobe
//   rsp_data      : returned quotient, qualified by rsp_valid
//   inflight      : accepted operations not yet returned
// -----------------------------------------------------------------------------
module fdiv_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  input  logic [31:0]           div_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [4:0]            inflight
);

  localparam int IW = $clog2(NUM_REQ);
  // One extra stage lines the tag up with the divider's registered input.
  localparam int NS = DIV_LATENCY + 1;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic          transfer;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;
  logic [NS-1:0] tag_valid;
  logic [IW-1:0] tag_idx [NS];

  // Round-robin search. The scan runs downward so that the candidate
  // closest to ptr is assigned last and therefore wins.
  always_comb begin
    cand      = '0;
    grant_idx = ptr;
    grant_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end else begin
        grant_idx = grant_idx;
        grant_any = grant_any;
      end
    end
    // While in reset, no grant is given.
    transfer  = grant_any & reset_n;
    req_ready = transfer ? onehot(grant_idx) : '0;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IW'(k)) begin
        sel_a = req_a[32*k +: 32];
        sel_b = req_b[32*k +: 32];
      end else begin
        sel_a = sel_a;
        sel_b = sel_b;
      end
    end
  end

  // Round-robin pointer and divider operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      div_a <= 32'h0000_0000;
      div_b <= 32'h0000_0000;
    end else if (transfer) begin
      ptr   <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      div_a <= sel_a;
      div_b <= sel_b;
    end
  end

  // Ownership tags travel alongside the divider pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      for (int s = 0; s < NS; s++) tag_idx[s] <= '0;
    end else begin
      tag_valid  <= {tag_valid[NS-2:0], transfer};
      tag_idx[0] <= grant_idx;
      for (int s = 1; s < NS; s++) tag_idx[s] <= tag_idx[s-1];
    end
  end

  // Response register. The quotient is passed through bit-exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_data  <= 32'h0000_0000;
    end else if (tag_valid[NS-1]) begin
      rsp_valid <= onehot(tag_idx[NS-1]);
      rsp_data  <= div_result;
    end else begin
      rsp_valid <= '0;
    end
  end

  // Outstanding-operation counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 5'd0;
    end else begin
      case ({transfer, |rsp_valid})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fdiv_arbiter
//   Self-checking bench for fdiv_arbiter (NUM_REQ=4, DIV_LATENCY=4).
//   The bench includes a stand-in divider. It is a fixed-latency delay line
//   over a lookup of known IEEE quotients, and it scrambles all other
//   operands. A scoreboard models the arbitration rules: the first valid
//   requester at or above ptr wins, with wrap-around. The scoreboard keeps a
//   queue of expected responses with due edges, and it derives inflight from
//   the acceptance edges.
// -----------------------------------------------------------------------------
module tb_fdiv_arbiter;

  localparam int NR = 4;
  localparam int L  = 4;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [32*NR-1:0]  req_a;
  logic [32*NR-1:0]  req_b;
  logic [NR-1:0]     req_ready;
  logic [31:0]       div_a;
  logic [31:0]       div_b;
  logic [31:0]       div_result;
  logic [NR-1:0]     rsp_valid;
  logic [31:0]       rsp_data;
  logic [4:0]        inflight;

  fdiv_arbiter #(.NUM_REQ(NR), .DIV_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h42F00000, 32'h41200000}: div_model = 32'h41400000;
      {32'h3F800000, 32'h40000000}: div_model = 32'h3F000000;
      {32'h40C00000, 32'h40400000}: div_model = 32'h40000000;
      {32'h3F800000, 32'h00000000}: div_model = 32'h7F800000;
      {32'h00000000, 32'h00000000}: div_model = 32'h7FC00000;
      default:                      div_model = a ^ {b[15:0], b[31:16]} ^ 32'h9E3779B9;
    endcase
  endfunction

  // Stand-in divider: the result appears L cycles after div_a/div_b.
  logic [31:0] dpipe [L];
  always @(posedge clk) begin
    dpipe[0] <= div_model(div_a, div_b);
    for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_result = dpipe[L-1];

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } rsp_t;

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] ready;
  } vec_t;

  rsp_t        rq[$];
  int          aq[$];
  int          m_ptr;
  logic [31:0] m_a, m_b, m_rsp;
  int          ecnt;
  int          checks;
  int          errors;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) set_ops(i, $urandom, $urandom);
  endtask

  // Checks all outputs against the model for the current cycle, then
  // advances through one rising edge.
  task automatic tick();
    int            g;
    logic [NR-1:0] er;
    rsp_t          e;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NR; k++)
      if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    if (rq.size() > 0 && rq[0].due == ecnt) begin
      e  = rq.pop_front();
      er = '0;
      er[e.idx] = 1'b1;
      chk("rsp_valid", rsp_valid, er);
      chk("rsp_data", rsp_data, e.data);
      m_rsp = e.data;
    end else begin
      chk("rsp_valid_idle", rsp_valid, 32'd0);
      chk("rsp_data_hold", rsp_data, m_rsp);
    end
    while (aq.size() > 0 && aq[0] + L + 2 <= ecnt) void'(aq.pop_front());
    chk("inflight", inflight, aq.size());
    chk("div_a", div_a, m_a);
    chk("div_b", div_b, m_b);
    @(posedge clk);
    ecnt++;
    if (g >= 0) begin
      m_a = req_a[32*g +: 32];
      m_b = req_b[32*g +: 32];
      rq.push_back('{g, div_model(m_a, m_b), ecnt + L + 1});
      aq.push_back(ecnt);
      m_ptr = (g + 1) % NR;
    end
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    rq.delete();
    aq.delete();
    m_ptr = 0;
    m_a   = 32'd0;
    m_b   = 32'd0;
    m_rsp = 32'd0;
    #1;
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_inflight", inflight, 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    req_valid = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ecnt      = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    // Arbitration sequence from reset (ptr starts at 0).
    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0001};
    tbl[2]  = '{4'b0001, 4'b0001};
    tbl[3]  = '{4'b1010, 4'b0010};
    tbl[4]  = '{4'b1010, 4'b1000};
    tbl[5]  = '{4'b0110, 4'b0010};
    tbl[6]  = '{4'b0110, 4'b0100};
    tbl[7]  = '{4'b0011, 4'b0001};
    tbl[8]  = '{4'b1111, 4'b0010};
    tbl[9]  = '{4'b1001, 4'b1000};
    tbl[10] = '{4'b0000, 4'b0000};
    tbl[11] = '{4'b1000, 4'b1000};

    apply_reset(3);
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid;
      rand_ops();
      #1;
      chk("tbl_ready", req_ready, tbl[i].ready);
      tick();
    end
    req_valid = '0;
    repeat (8) tick();

    // Single operation: 120.0 / 10.0 from requester 0.
    apply_reset(2);
    set_ops(0, 32'h42F00000, 32'h41200000);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("single_inflight_1", inflight, 32'd1);
    repeat (5) tick();
    chk("single_rsp_valid", rsp_valid, 32'h1);
    chk("single_rsp_data", rsp_data, 32'h41400000);
    tick();
    chk("single_inflight_0", inflight, 32'd0);

    // All requesters valid continuously right after reset.
    apply_reset(2);
    for (int k = 0; k < 16; k++) begin
      req_valid = 4'b1111;
      rand_ops();
      #1;
      chk("stream_grant", req_ready, 32'h1 << (k % NR));
      tick();
      if (k >= 5) chk("stream_rsp", rsp_valid, 32'h1 << ((k - 5) % NR));
    end
    req_valid = '0;
    repeat (8) tick();

    // Requesters 1 and 3 collide with ptr=2.
    apply_reset(2);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    set_ops(1, 32'h3F800000, 32'h40000000);
    set_ops(3, 32'h40C00000, 32'h40400000);
    #1;
    chk("collide_first", req_ready, 32'b1000);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("collide_second", req_ready, 32'b0010);
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("collide_rsp3", rsp_valid, 32'b1000);
    chk("collide_data3", rsp_data, 32'h40000000);
    tick();
    chk("collide_rsp1", rsp_valid, 32'b0010);
    chk("collide_data1", rsp_data, 32'h3F000000);
    repeat (3) tick();

    // Divide by zero and 0/0, back to back: quotients pass through unmodified.
    set_ops(2, 32'h3F800000, 32'h00000000);
    req_valid = 4'b0100;
    tick();
    set_ops(0, 32'h00000000, 32'h00000000);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("inf_rsp", rsp_valid, 32'b0100);
    chk("inf_data", rsp_data, 32'h7F800000);
    tick();
    chk("nan_rsp", rsp_valid, 32'b0001);
    chk("nan_data", rsp_data, 32'h7FC00000);
    repeat (3) tick();

    // Reset in the middle of three in-flight operations.
    for (int i = 0; i < 3; i++) begin
      req_valid = '0;
      req_valid[i] = 1'b1;
      rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    apply_reset(2);
    chk("post_rst_inflight", inflight, 32'd0);
    repeat (8) tick();
    req_valid = 4'b1111;
    #1;
    chk("post_rst_ptr0", req_ready, 32'b0001);
    req_valid = 4'b0100;
    set_ops(2, 32'h42F00000, 32'h41200000);
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("post_rst_rsp", rsp_valid, 32'b0100);
    chk("post_rst_data", rsp_data, 32'h41400000);
    repeat (2) tick();

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (10) tick();
    chk("drain_inflight", inflight, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one divider (range 2..8).
REQ-003 Parameter DIV_LATENCY, default 4, SHALL set the fixed cycles from div_a/div_b presented to div_result valid (range 1..16).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_a  input  32*NUM_REQ  IEEE-754 single dividends; requester i occupies bits [32i+31:32i].
REQ-008 req_b  input  32*NUM_REQ  IEEE-754 single divisors, same packing as req_a.
REQ-009 req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-010 div_a  output  32  registered dividend to the pipelined divider.
REQ-011 div_b  output  32  registered divisor to the pipelined divider.
REQ-012 div_result  input  32  divider quotient, valid DIV_LATENCY cycles after the matching div_a/div_b.
REQ-013 rsp_valid  output  NUM_REQ  one-hot, single-cycle result strobe to the owning requester.
REQ-014 rsp_data  output  32  quotient, qualified by rsp_valid.
REQ-015 inflight  output  5  count of accepted operations not yet returned on rsp_valid.

Function
REQ-016 req_ready SHALL be combinational from req_valid and the round-robin pointer, with at most one bit high and zero bits high when req_valid is all zero.
REQ-017 Grant SHALL go to the first requester with req_valid high, searching upward from pointer ptr and wrapping at NUM_REQ-1 to 0.
REQ-018 After a transfer to requester g, ptr SHALL become (g+1) mod NUM_REQ; with no transfer, ptr SHALL hold.
REQ-019 On a transfer, div_a/div_b SHALL load the granted requester's operands at that edge; with no transfer they SHALL hold their value.
REQ-020 A tag pipeline of DIV_LATENCY+1 stages, each {valid, index}, SHALL load stage 0 at each edge ({1,g} on a transfer, else {0,x}) and shift one stage per cycle.
REQ-021 When the last tag stage is valid, the next edge SHALL register rsp_data <= div_result and rsp_valid <= one-hot(index); otherwise rsp_valid SHALL be zero and rsp_data SHALL hold.
REQ-022 End-to-end latency SHALL be fixed: transfer at edge t -> rsp_valid high for exactly the cycle after edge t+DIV_LATENCY+1; sustained throughput SHALL be one operation per cycle.
REQ-023 Responses SHALL return in acceptance order and SHALL have no backpressure; requesters always accept rsp_valid.
REQ-024 inflight SHALL increment on a transfer, decrement on an rsp_valid edge, and stay unchanged when both occur in the same cycle; its maximum is DIV_LATENCY+2.
REQ-025 A requester deasserting req_valid without a transfer SHALL NOT be granted and SHALL leave ptr unchanged.
REQ-026 A requester SHALL be able to receive rsp_valid and a new req_ready in the same cycle.
REQ-027 Quotient bits, including NaN, Inf and zero encodings, SHALL pass from div_result to rsp_data unmodified.
REQ-028 Any requester holding req_valid SHALL be granted within NUM_REQ cycles.

Reset
REQ-029 While reset_n is low: ptr=0, all tag stages invalid, div_a=div_b=0, rsp_data=0, rsp_valid=0, inflight=0, and req_ready forced to 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight tags, so no rsp_valid is produced for operations accepted before reset.

Verification
REQ-031 Single op, requester 0, A=0x42F00000 (120.0), B=0x41200000 (10.0), DIV_LATENCY=4 -> rsp_valid=0001 and rsp_data=0x41400000 (12.0) in the cycle after edge t+5; inflight goes 1 then back to 0.
REQ-032 All four requesters valid continuously from reset release -> grants in the order 0,1,2,3,0,..., one per cycle, and responses in the same order, six cycles after each grant.
REQ-033 Requester 1 sends 0x3F800000/0x40000000 (1.0/2.0) and requester 3 sends 0x40C00000/0x40400000 (6.0/3.0) on the same cycle with ptr=2 -> requester 3 is granted first, returning 0x40000000, then requester 1, returning 0x3F000000.
REQ-034 Divide by zero, 0x3F800000/0x00000000 -> rsp_data equals the divider output exactly (0x7F800000 from an IEEE-correct divider).
REQ-035 Reset pulsed 2 cycles after three transfers -> no rsp_valid afterwards, inflight=0, and ptr=0; a new request after reset completes normally.
